// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, pattern type and capture FSM states shared by the
// 7-segment readback decoder. Segment order is bit6=a ... bit0=g, active low.
package seg7_pkg;

  typedef logic [6:0] seg7_pattern_t;

  localparam seg7_pattern_t SEG7_GLYPH_0 = 7'b0000001;
  localparam seg7_pattern_t SEG7_GLYPH_1 = 7'b1001111;
  localparam seg7_pattern_t SEG7_GLYPH_2 = 7'b0010010;
  localparam seg7_pattern_t SEG7_GLYPH_3 = 7'b0000110;
  localparam seg7_pattern_t SEG7_GLYPH_4 = 7'b1001100;
  localparam seg7_pattern_t SEG7_GLYPH_5 = 7'b0100100;
  localparam seg7_pattern_t SEG7_GLYPH_6 = 7'b0100000;
  localparam seg7_pattern_t SEG7_GLYPH_7 = 7'b0001111;
  localparam seg7_pattern_t SEG7_GLYPH_8 = 7'b0000000;
  localparam seg7_pattern_t SEG7_GLYPH_9 = 7'b0001100;
  localparam seg7_pattern_t SEG7_GLYPH_A = 7'b0001000;
  localparam seg7_pattern_t SEG7_GLYPH_B = 7'b1100000;
  localparam seg7_pattern_t SEG7_GLYPH_C = 7'b0110001;
  localparam seg7_pattern_t SEG7_GLYPH_E = 7'b0110000;
  localparam seg7_pattern_t SEG7_GLYPH_F = 7'b0111000;
  localparam seg7_pattern_t SEG7_BLANK   = 7'h7F;

  // IDLE: no valid selection; SETTLE: counting identical samples; HOLD: captured.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg7_cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational glyph-to-nibble lookup. A pattern is either
// a recognised hex glyph (is_valid), all segments off (is_blank), or neither.
// The value 13 has no glyph and is never produced.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       is_valid,
  output logic       is_blank
);

  // Table lookup; anything not listed falls to the unrecognised default.
  always_comb begin
    nibble   = 4'h0;
    is_valid = 1'b1;
    is_blank = 1'b0;
    case (seg_n)
      SEG7_GLYPH_0: nibble = 4'h0;
      SEG7_GLYPH_1: nibble = 4'h1;
      SEG7_GLYPH_2: nibble = 4'h2;
      SEG7_GLYPH_3: nibble = 4'h3;
      SEG7_GLYPH_4: nibble = 4'h4;
      SEG7_GLYPH_5: nibble = 4'h5;
      SEG7_GLYPH_6: nibble = 4'h6;
      SEG7_GLYPH_7: nibble = 4'h7;
      SEG7_GLYPH_8: nibble = 4'h8;
      SEG7_GLYPH_9: nibble = 4'h9;
      SEG7_GLYPH_A: nibble = 4'hA;
      SEG7_GLYPH_B: nibble = 4'hB;
      SEG7_GLYPH_C: nibble = 4'hC;
      SEG7_GLYPH_E: nibble = 4'hE;
      SEG7_GLYPH_F: nibble = 4'hF;
      SEG7_BLANK: begin
        is_valid = 1'b0;
        is_blank = 1'b1;
      end
      default: is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples a multiplexed active-low 7-segment bus, waits for
// STABLE_CYCLES identical synchronised (select, segment) samples, then latches
// the decoded nibble for the selected digit. capture_stb rises
// SYNC_STAGES + STABLE_CYCLES - 1 clocks after the edge that first samples a
// new bus value. Optional macro SEG7_DP_EN adds the decimal point (dp_n in,
// digit_dp out, dp lit = 1), which also takes part in the stability compare.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         dig_sel_n,
`ifdef SEG7_DP_EN
  input  logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         digit_dp,
`endif
  input  logic                          clr_err,
  output logic [4*NUM_DIGITS-1:0]       values,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         digit_blank,
  output logic                          capture_stb,
  output logic [$clog2(NUM_DIGITS)-1:0] capture_idx,
  output logic                          frame_done,
  output logic                          err_pattern
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef SEG7_DP_EN
  localparam int PW = NUM_DIGITS + 8;
`else
  localparam int PW = NUM_DIGITS + 7;
`endif
  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  // Packed sample: {[dp_n,] seg_n, dig_sel_n}
  logic [PW-1:0]         pair_in;
  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         pair;
  logic [PW-1:0]         prev_q;
  logic [NUM_DIGITS-1:0] sel;
  seg7_pattern_t         seg;
  logic                  sel_ok;
  logic                  changed;
  logic [IDX_W-1:0]      sel_idx;

  seg7_cap_state_t       state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  cap;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] seen_q;
  logic                  frame_full;

  logic [3:0]            dec_nibble;
  logic                  dec_valid;
  logic                  dec_blank;

`ifdef SEG7_DP_EN
  assign pair_in = {dp_n, seg_n, dig_sel_n};
`else
  assign pair_in = {seg_n, dig_sel_n};
`endif

  assign pair       = sync_q[SYNC_STAGES-1];
  assign sel        = pair[NUM_DIGITS-1:0];
  assign seg        = pair[NUM_DIGITS +: 7];
  assign sel_ok     = $onehot(~sel);
  assign changed    = (pair != prev_q);
  assign cap_mask   = cap ? ~sel : {NUM_DIGITS{1'b0}};
  assign frame_full = &seen_q;

  seg7_pattern_decode u_decode (
    .seg_n    (seg),
    .nibble   (dec_nibble),
    .is_valid (dec_valid),
    .is_blank (dec_blank)
  );

  // Input synchroniser chain plus the previous synchronised sample for the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pair_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pair;
    end
  end

  // Index of the single low select bit (only meaningful when sel_ok).
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Capture FSM state and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a run of identical valid samples reaching STABLE_CYCLES captures once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == STABLE_CNT) begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered results: per-digit latch on capture, frame tracking, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      values      <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      capture_stb <= 1'b0;
      capture_idx <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      seen_q      <= '0;
`ifdef SEG7_DP_EN
      digit_dp    <= '0;
`endif
    end else begin
      capture_stb <= cap;
      frame_done  <= frame_full;
      // A capture on the pulse edge starts the next frame's mask.
      seen_q      <= (frame_full ? {NUM_DIGITS{1'b0}} : seen_q) | cap_mask;
      if (cap) capture_idx <= sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          if (dec_valid) begin
            values[4*i +: 4] <= dec_nibble;
            digit_valid[i]   <= 1'b1;
            digit_blank[i]   <= 1'b0;
          end else if (dec_blank) begin
            values[4*i +: 4] <= 4'h0;
            digit_valid[i]   <= 1'b0;
            digit_blank[i]   <= 1'b1;
          end else begin
            digit_valid[i]   <= 1'b0;
            digit_blank[i]   <= 1'b0;
          end
`ifdef SEG7_DP_EN
          digit_dp[i] <= ~pair[PW-1];
`endif
        end
      end
      // A new error beats a simultaneous clear.
      if (cap && !dec_valid && !dec_blank) err_pattern <= 1'b1;
      else if (clr_err)                    err_pattern <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: directed scenarios plus randomized bus traffic, all
// outputs compared every cycle against a run-length reference model.
module tb_seg7_capture_decoder;
  import seg7_pkg::*;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int SS = 2;
  localparam int IW = $clog2(N);
`ifdef SEG7_DP_EN
  localparam bit DP_ON = 1'b1;
`else
  localparam bit DP_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]     seg_n     = 7'h7F;
  logic [N-1:0]   dig_sel_n = '1;
  logic           clr_err   = 1'b0;
  logic           dp_n      = 1'b1;
  logic [4*N-1:0] values;
  logic [N-1:0]   digit_valid, digit_blank;
  logic           capture_stb, frame_done, err_pattern;
  logic [IW-1:0]  capture_idx;
`ifdef SEG7_DP_EN
  logic [N-1:0]   digit_dp;
`endif

  seg7_capture_decoder #(
    .NUM_DIGITS(N), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
`ifdef SEG7_DP_EN
    .dp_n        (dp_n),
    .digit_dp    (digit_dp),
`endif
    .clr_err     (clr_err),
    .values      (values),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .capture_stb (capture_stb),
    .capture_idx (capture_idx),
    .frame_done  (frame_done),
    .err_pattern (err_pattern)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stb_cnt  = 0;
  int fd_cnt   = 0;
  int last_stb_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 13 has no glyph; its slot is skipped in the lookup.
  logic [6:0] glyph_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1111111, 7'b0110000, 7'b0111000};

  // 0..15 = hex glyph, 16 = blank, -1 = unrecognised
  function automatic int classify(input logic [6:0] p);
    if (p == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) begin
      if (i != 13 && glyph_tbl[i] == p) return i;
    end
    return -1;
  endfunction

  logic [N-1:0] hist_sel [$];
  logic [6:0]   hist_seg [$];
  logic         hist_dp  [$];
  logic [N-1:0] prev_sel, s_sel;
  logic [6:0]   prev_seg, s_seg;
  logic         prev_dp, s_dp;
  int           run;
  logic [4*N-1:0] m_values;
  logic [N-1:0] m_valid, m_blank, m_seen, m_dp;
  logic         m_stb, m_fd, m_err;
  logic [IW-1:0] m_idx;

  // The design sees the bus SS edges late; a capture happens on the edge where
  // the run of identical valid samples reaches exactly SC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_sel = {}; hist_seg = {}; hist_dp = {};
      for (int i = 0; i < SS; i++) begin
        hist_sel.push_back('0); hist_seg.push_back('0); hist_dp.push_back(1'b0);
      end
      prev_sel = '0; prev_seg = '0; prev_dp = 1'b0; run = 0;
      m_values = '0; m_valid = '0; m_blank = '0; m_seen = '0; m_dp = '0;
      m_stb = 1'b0; m_fd = 1'b0; m_err = 1'b0; m_idx = '0;
    end else begin
      s_sel = hist_sel.pop_front(); hist_sel.push_back(dig_sel_n);
      s_seg = hist_seg.pop_front(); hist_seg.push_back(seg_n);
      s_dp  = hist_dp.pop_front();  hist_dp.push_back(dp_n);
      if ($countones(~s_sel) != 1) run = 0;
      else if (s_sel == prev_sel && s_seg == prev_seg && (!DP_ON || s_dp == prev_dp)) begin
        if (run <= SC) run++;
      end else run = 1;
      prev_sel = s_sel; prev_seg = s_seg; prev_dp = s_dp;

      m_fd = (m_seen == '1);
      if (m_fd) m_seen = '0;
      m_stb = (run == SC);
      if (m_stb) begin
        int g;
        for (int i = N - 1; i >= 0; i--) if (!s_sel[i]) m_idx = IW'(i);
        m_seen[m_idx] = 1'b1;
        m_dp[m_idx]   = ~s_dp;
        g = classify(s_seg);
        if (g == 16) begin
          m_values[4*m_idx +: 4] = 4'h0; m_valid[m_idx] = 1'b0; m_blank[m_idx] = 1'b1;
        end else if (g < 0) begin
          m_valid[m_idx] = 1'b0; m_blank[m_idx] = 1'b0; m_err = 1'b1;
        end else begin
          m_values[4*m_idx +: 4] = 4'(g); m_valid[m_idx] = 1'b1; m_blank[m_idx] = 1'b0;
        end
      end
      if (!(m_stb && classify(s_seg) < 0) && clr_err) m_err = 1'b0;
    end
  end

  always @(posedge clk) cyc++;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("capture_stb", 32'(capture_stb), 32'(m_stb));
    check("capture_idx", 32'(capture_idx), 32'(m_idx));
    check("values",      32'(values),      32'(m_values));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("digit_blank", 32'(digit_blank), 32'(m_blank));
    check("frame_done",  32'(frame_done),  32'(m_fd));
    check("err_pattern", 32'(err_pattern), 32'(m_err));
`ifdef SEG7_DP_EN
    check("digit_dp",    32'(digit_dp),    32'(m_dp));
`endif
    if (capture_stb) begin stb_cnt++; last_stb_cyc = cyc; end
    if (frame_done) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] sel, input logic [6:0] seg, input int cycles);
    dig_sel_n = sel;
    seg_n     = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, f0, start, r, g;
    logic [N-1:0] rsel;
    logic [6:0]   rseg;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_values", 32'(values), 32'h0);
    check("rst_stb",    32'(capture_stb), 32'h0);
    check("rst_fd",     32'(frame_done), 32'h0);
    check("rst_err",    32'(err_pattern), 32'h0);
    check("rst_state",  32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Stable digit 0 showing '2'
    s0 = stb_cnt; start = cyc;
    drive(4'b1110, 7'b0010010, 10);
    #1;
    check("t1_strobes", 32'(stb_cnt - s0), 32'd1);
    check("t1_latency", 32'(last_stb_cyc - (start + 1)), 32'(SS + SC - 1));
    check("t1_value",   32'(values[3:0]), 32'h2);
    check("t1_valid0",  32'(digit_valid[0]), 32'h1);
    check("t1_idx",     32'(capture_idx), 32'h0);

    // Glitching digit 1, then a steady 'A'
    s0 = stb_cnt;
    for (int k = 0; k < 4; k++) drive(4'b1101, (k % 2 == 0) ? 7'b0000110 : 7'b0000000, 2);
    #1 check("t2_no_glitch_cap", 32'(stb_cnt - s0), 32'd0);
    drive(4'b1101, 7'b0001000, 8);
    #1;
    check("t2_strobes", 32'(stb_cnt - s0), 32'd1);
    check("t2_value",   32'(values[7:4]), 32'hA);

    // Blank on digit 2; '7' then a bad pattern on digit 3; clear
    drive(4'b1011, 7'h7F, 8);
    #1;
    check("t3_blank2", 32'(digit_blank[2]), 32'h1);
    check("t3_err0",   32'(err_pattern), 32'h0);
    drive(4'b0111, 7'b0001111, 8);
    drive(4'b0111, 7'b1000010, 8);
    #1;
    check("t3_err1",    32'(err_pattern), 32'h1);
    check("t3_keep3",   32'(values[15:12]), 32'h7);
    check("t3_valid3",  32'(digit_valid[3]), 32'h0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    #1 check("t3_cleared", 32'(err_pattern), 32'h0);

    // Full frame 1,b,C,F then a lone rescan of digit 0
    do_reset();
    s0 = stb_cnt; f0 = fd_cnt;
    drive(4'b1110, 7'b1001111, 6);
    drive(4'b1101, 7'b1100000, 6);
    drive(4'b1011, 7'b0110001, 6);
    drive(4'b0111, 7'b0111000, 6);
    drive(4'b1111, 7'h7F, 5);
    #1;
    check("t4_strobes", 32'(stb_cnt - s0), 32'd4);
    check("t4_frames",  32'(fd_cnt - f0), 32'd1);
    check("t4_values",  32'(values), 32'hFCB1);
    s0 = stb_cnt; f0 = fd_cnt;
    drive(4'b1110, 7'b1001111, 6);
    drive(4'b1111, 7'h7F, 5);
    #1;
    check("t4_rescan_strobe", 32'(stb_cnt - s0), 32'd1);
    check("t4_rescan_frames", 32'(fd_cnt - f0), 32'd0);

    // Invalid selections, then reset while settling
    s0 = stb_cnt;
    drive(4'b1100, 7'b0000000, 20);
    drive(4'b1111, 7'b0000000, 20);
    #1;
    check("t5_no_cap",   32'(stb_cnt - s0), 32'd0);
    check("t5_idle",     32'(dut.state_q), 32'(IDLE));
    drive(4'b1110, 7'b0100100, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_values", 32'(values), 32'h0);
    check("t5_rst_valid",  32'(digit_valid), 32'h0);
    check("t5_rst_stb",    32'(capture_stb), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = stb_cnt; start = cyc;
    repeat (10) @(negedge clk);
    #1;
    check("t5_recap",      32'(stb_cnt - s0), 32'd1);
    check("t5_recap_lat",  32'(last_stb_cyc - (start + 1)), 32'(SS + SC - 1));
    check("t5_recap_val",  32'(values[3:0]), 32'h5);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) rsel = ~(N'(1) << $urandom_range(0, N - 1));
      else       rsel = N'($urandom_range(0, (1 << N) - 1));
      r = $urandom_range(0, 9);
      if (r < 6) begin
        g = $urandom_range(0, 14);
        if (g >= 13) g++;
        rseg = glyph_tbl[g];
      end else if (r < 7) rseg = 7'h7F;
      else rseg = 7'($urandom);
`ifdef SEG7_DP_EN
      dp_n = 1'($urandom);
`endif
      clr_err = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive(rsel, rseg, $urandom_range(1, 10));
    end
    clr_err = 1'b0;
    drive(4'b1111, 7'h7F, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
